// File: rtl/psum_pkg.sv
// Shared definitions for the PSUM drain path: state encoding, default
// geometry, lane slicing helper and an SRAM access bundle.
package psum_pkg;

    // Default geometry of the corelet output vector and PSUM SRAM.
    localparam int PSUM_COL    = 8;
    localparam int PSUM_BW     = 16;
    localparam int PSUM_ADDR_W = 11;

    // Drain FSM state encoding.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WR   = 3'd1;
    localparam logic [2:0] ST_RD   = 3'd2;
    localparam logic [2:0] ST_ACC  = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    // One SRAM access at default geometry (active-low enables).
    typedef struct packed {
        logic                          cen;
        logic                          wen;
        logic [PSUM_ADDR_W-1:0]        addr;
        logic [PSUM_COL*PSUM_BW-1:0]   d;
    } sram_acc_t;

    // LSB position of a lane; lane 0 sits at the bottom of the vector.
    function automatic int lane_lsb(input int lane, input int bw);
        return lane * bw;
    endfunction

endpackage

// File: rtl/psum_lane_add.sv
// Column-parallel wrap-around adder: each lane is summed independently and
// truncated to the lane width (two's-complement wrap, no saturation).
module psum_lane_add
    import psum_pkg::*;
#(
    parameter int col     = PSUM_COL,
    parameter int psum_bw = PSUM_BW
) (
    input  logic [col*psum_bw-1:0] a,
    input  logic [col*psum_bw-1:0] b,
    output logic [col*psum_bw-1:0] sum
);

    for (genvar gi = 0; gi < col; gi++) begin : g_lane
        assign sum[lane_lsb(gi, psum_bw) +: psum_bw] =
            a[lane_lsb(gi, psum_bw) +: psum_bw] + b[lane_lsb(gi, psum_bw) +: psum_bw];
    end

endmodule

// File: rtl/psum_drain.sv
// Drains output vectors from the corelet OFIFO into the PSUM SRAM at
// consecutive addresses, optionally accumulating onto the stored partials.
module psum_drain
    import psum_pkg::*;
#(
    parameter int col     = PSUM_COL,
    parameter int psum_bw = PSUM_BW,
    parameter int addr_w  = PSUM_ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    acc_en,
    input  logic [addr_w-1:0]       base_addr,
    input  logic [addr_w-1:0]       num_vec,
    input  logic                    ofifo_valid,
    input  logic [col*psum_bw-1:0]  ofifo_out,
    output logic                    ofifo_rd,
    output logic                    sram_cen,
    output logic                    sram_wen,
    output logic [addr_w-1:0]       sram_addr,
    output logic [col*psum_bw-1:0]  sram_d,
    input  logic [col*psum_bw-1:0]  sram_q,
    output logic                    busy,
    output logic                    done
);

    localparam logic [addr_w-1:0] ONE  = {{(addr_w-1){1'b0}}, 1'b1};
    localparam logic [addr_w-1:0] ZERO = '0;

    logic [2:0]              state_q, state_d;
    logic [addr_w-1:0]       addr_q, addr_d;
    logic [addr_w-1:0]       remaining_q, remaining_d;
    logic [col*psum_bw-1:0]  acc_sum;

    // Stored partial (read in RD, returned in ACC) plus the OFIFO head.
    psum_lane_add #(
        .col     (col),
        .psum_bw (psum_bw)
    ) u_lane_add (
        .a   (sram_q),
        .b   (ofifo_out),
        .sum (acc_sum)
    );

    // State and counter registers; reset abandons any job in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= ZERO;
            remaining_q <= ZERO;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
        end
    end

    // Next-state logic: job launch, per-vector address/count stepping.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = num_vec;
                    if (num_vec == ZERO) begin
                        state_d = ST_FIN;
                    end else if (acc_en) begin
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end
            ST_WR: begin
                if (ofifo_valid) begin
                    addr_d      = addr_q + ONE;
                    remaining_d = remaining_q - ONE;
                    if (remaining_q == ONE) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_RD: begin
                if (ofifo_valid) begin
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                addr_d      = addr_q + ONE;
                remaining_d = remaining_q - ONE;
                state_d     = (remaining_q == ONE) ? ST_FIN : ST_RD;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // SRAM and OFIFO strobes decoded from the current state and OFIFO valid.
    always_comb begin
        ofifo_rd  = 1'b0;
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        sram_addr = ZERO;
        sram_d    = '0;
        case (state_q)
            ST_WR: begin
                if (ofifo_valid) begin
                    ofifo_rd  = 1'b1;
                    sram_cen  = 1'b0;
                    sram_wen  = 1'b0;
                    sram_addr = addr_q;
                    sram_d    = ofifo_out;
                end
            end
            ST_RD: begin
                if (ofifo_valid) begin
                    sram_cen  = 1'b0;
                    sram_addr = addr_q;
                end
            end
            ST_ACC: begin
                // The head was seen valid in RD and nothing else pops it.
                ofifo_rd  = 1'b1;
                sram_cen  = 1'b0;
                sram_wen  = 1'b0;
                sram_addr = addr_q;
                sram_d    = acc_sum;
            end
            default: begin
                ofifo_rd = 1'b0;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign done = (state_q == ST_FIN);

endmodule

// File: tb/tb_psum_drain.sv
// Bench for psum_drain: behavioural SRAM and OFIFO models, per-job
// expectations computed from addresses, lane arithmetic and cycle counts.
module tb_psum_drain;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int AW    = 11;
    localparam int VW    = COL * BW;
    localparam int DEPTH = 2048;

    logic          clk;
    logic          reset;
    logic          start;
    logic          acc_en;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] num_vec;
    logic          ofifo_valid;
    logic [VW-1:0] ofifo_out;
    logic          ofifo_rd;
    logic          sram_cen;
    logic          sram_wen;
    logic [AW-1:0] sram_addr;
    logic [VW-1:0] sram_d;
    logic [VW-1:0] sram_q;
    logic          busy;
    logic          done;

    psum_drain #(
        .col     (COL),
        .psum_bw (BW),
        .addr_w  (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .acc_en      (acc_en),
        .base_addr   (base_addr),
        .num_vec     (num_vec),
        .ofifo_valid (ofifo_valid),
        .ofifo_out   (ofifo_out),
        .ofifo_rd    (ofifo_rd),
        .sram_cen    (sram_cen),
        .sram_wen    (sram_wen),
        .sram_addr   (sram_addr),
        .sram_d      (sram_d),
        .sram_q      (sram_q),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            rel;
        logic [AW-1:0] addr;
        logic [VW-1:0] d;
    } rec_t;

    logic [VW-1:0] mem [0:DEPTH-1];
    logic [VW-1:0] fifo_q[$];
    bit            vpat[$];
    logic [VW-1:0] job_vecs[$];
    logic [VW-1:0] old_vals[$];
    rec_t          wr_log[$];
    rec_t          rd_log[$];
    int            done_rels[$];
    int            busy_cnt;
    int            pop_cnt;
    int            cyc;
    int            start_cyc;
    int            checks;
    int            errors;

    logic          cap_cen, cap_wen, cap_rd;
    logic [AW-1:0] cap_addr;
    logic [VW-1:0] cap_d;

    function automatic logic [VW-1:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [VW-1:0] fill(input logic [BW-1:0] v);
        logic [VW-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = v;
        return r;
    endfunction

    // Lane-wise integer sum, reduced modulo 2^BW.
    function automatic logic [VW-1:0] ref_add(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] r;
        for (int i = 0; i < COL; i++) begin
            int s;
            s = (int'(a[i*BW +: BW]) + int'(b[i*BW +: BW])) % 65536;
            r[i*BW +: BW] = s[BW-1:0];
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] wrap(input logic [AW-1:0] b, input int k);
        return AW'((int'(b) + k) % DEPTH);
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample DUT at negedge, apply SRAM/OFIFO effects at posedge, drive at +1.
    task automatic tick();
        rec_t r;
        bit   v;
        @(negedge clk);
        cap_cen  = sram_cen;
        cap_wen  = sram_wen;
        cap_rd   = ofifo_rd;
        cap_addr = sram_addr;
        cap_d    = sram_d;
        r.rel  = cyc - start_cyc;
        r.addr = sram_addr;
        r.d    = sram_d;
        if (!sram_cen) begin
            if (!sram_wen) wr_log.push_back(r);
            else           rd_log.push_back(r);
        end
        if (ofifo_rd) pop_cnt++;
        if (done) done_rels.push_back(cyc - start_cyc);
        if (busy) busy_cnt++;
        @(posedge clk);
        if (!cap_cen) begin
            if (!cap_wen) mem[cap_addr] = cap_d;
            else          sram_q = mem[cap_addr];
        end
        if (cap_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        cyc++;
        #1;
        v = 1'b1;
        if (vpat.size() > 0) v = vpat.pop_front();
        ofifo_valid = v && (fifo_q.size() > 0);
        ofifo_out   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic launch(input logic acc, input logic [AW-1:0] base, input int n);
        wr_log.delete();
        rd_log.delete();
        done_rels.delete();
        old_vals.delete();
        busy_cnt = 0;
        pop_cnt  = 0;
        for (int k = 0; k < n; k++) begin
            old_vals.push_back(mem[wrap(base, k)]);
            fifo_q.push_back(job_vecs[k]);
        end
        acc_en    = acc;
        base_addr = base;
        num_vec   = AW'(n);
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start     = 1'b0;
        acc_en    = 1'($urandom);
        base_addr = AW'($urandom);
        num_vec   = AW'($urandom);
    endtask

    // Contents, ordering, pop/read counts and (if timed) cycle placement.
    task automatic check_job(input logic acc, input logic [AW-1:0] base, input int n, input bit timed);
        logic [VW-1:0] exp;
        int            exp_done;
        $display("job acc=%0d base=%03h n=%0d writes=%0d reads=%0d pops=%0d dones=%0d",
                 acc, base, n, wr_log.size(), rd_log.size(), pop_cnt, done_rels.size());
        chk("write_count", wr_log.size(), n);
        chk("read_count", rd_log.size(), acc ? n : 0);
        chk("pop_count", pop_cnt, n);
        chk("done_count", done_rels.size(), 1);
        for (int k = 0; k < n; k++) begin
            exp = acc ? ref_add(old_vals[k], job_vecs[k]) : job_vecs[k];
            chk("mem_data", mem[wrap(base, k)], exp);
            if (k < wr_log.size()) begin
                chk("wr_addr", wr_log[k].addr, wrap(base, k));
                chk("wr_data", wr_log[k].d, exp);
                if (timed) chk("wr_cycle", wr_log[k].rel, acc ? 2*k + 2 : k + 1);
            end
            if (acc && k < rd_log.size()) begin
                chk("rd_addr", rd_log[k].addr, wrap(base, k));
                if (timed) chk("rd_cycle", rd_log[k].rel, 2*k + 1);
            end
        end
        if (n == 0)               exp_done = 1;
        else if (timed)           exp_done = acc ? 2*n + 1 : n + 1;
        else if (wr_log.size() > 0) exp_done = wr_log[wr_log.size()-1].rel + 1;
        else                      exp_done = -1;
        if (done_rels.size() > 0) chk("done_cycle", done_rels[0], exp_done);
        chk("busy_cycles", busy_cnt, exp_done - 1);
    endtask

    initial begin
        logic [AW-1:0] b;
        bit            pat[$];
        int            cnt;
        int            exp_rels[$];

        checks = 0; errors = 0; cyc = 0; start_cyc = 0;
        busy_cnt = 0; pop_cnt = 0;
        reset = 1'b1; start = 1'b0; acc_en = 1'b0;
        base_addr = '0; num_vec = '0; ofifo_valid = 1'b0; ofifo_out = '0;
        sram_q = '0;
        for (int a = 0; a < DEPTH; a++) mem[a] = '0;

        // Reset state
        #3 reset = 1'b0;
        #5;
        chk("rst_cen", sram_cen, 1);
        chk("rst_wen", sram_wen, 1);
        chk("rst_addr", sram_addr, 0);
        chk("rst_d", sram_d, 0);
        chk("rst_rd", ofifo_rd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        ticks(2);

        // Plain write, lane0 = 1..4
        job_vecs.delete();
        for (int k = 0; k < 4; k++) begin
            logic [VW-1:0] v;
            v = rand_vec();
            v[BW-1:0] = BW'(k + 1);
            job_vecs.push_back(v);
        end
        launch(1'b0, 11'h010, 4);
        ticks(7);
        check_job(1'b0, 11'h010, 4, 1'b1);

        // Stall: valid 1,0,0,1,1
        job_vecs.delete();
        for (int k = 0; k < 3; k++) job_vecs.push_back(rand_vec());
        vpat = '{1, 0, 0, 1, 1};
        b = AW'($urandom);
        launch(1'b0, b, 3);
        ticks(8);
        check_job(1'b0, b, 3, 1'b0);
        if (wr_log.size() == 3) begin
            chk("stall_wr0", wr_log[0].rel, 1);
            chk("stall_wr1", wr_log[1].rel, 4);
            chk("stall_wr2", wr_log[2].rel, 5);
        end

        // Accumulate: 100 + 23, -5 + 7
        mem[11'h020] = fill(16'd100);
        mem[11'h021] = fill(16'hFFFB);
        job_vecs.delete();
        job_vecs.push_back(fill(16'd23));
        job_vecs.push_back(fill(16'd7));
        launch(1'b1, 11'h020, 2);
        ticks(8);
        check_job(1'b1, 11'h020, 2, 1'b1);
        chk("acc_123", mem[11'h020], fill(16'd123));
        chk("acc_2", mem[11'h021], fill(16'd2));

        // Lane overflow and address wrap
        mem[11'h7FF] = rand_vec();
        mem[11'h7FF][3*BW +: BW] = 16'h7FFF;
        mem[11'h000] = rand_vec();
        job_vecs.delete();
        job_vecs.push_back(rand_vec());
        job_vecs[0][3*BW +: BW] = 16'h0001;
        job_vecs.push_back(rand_vec());
        launch(1'b1, 11'h7FF, 2);
        ticks(8);
        check_job(1'b1, 11'h7FF, 2, 1'b1);
        chk("ovf_lane3", mem[11'h7FF][3*BW +: BW], 16'h8000);
        if (wr_log.size() == 2) chk("wrap_addr", wr_log[1].addr, 11'h000);

        // Random accumulate job
        job_vecs.delete();
        b = AW'($urandom);
        for (int k = 0; k < 5; k++) begin
            mem[wrap(b, k)] = rand_vec();
            job_vecs.push_back(rand_vec());
        end
        launch(1'b1, b, 5);
        ticks(14);
        check_job(1'b1, b, 5, 1'b1);

        // Random plain job under a random valid pattern
        job_vecs.delete();
        for (int k = 0; k < 6; k++) job_vecs.push_back(rand_vec());
        pat.delete();
        for (int i = 0; i < 30; i++) pat.push_back((i >= 24) ? 1'b1 : 1'($urandom));
        vpat = pat;
        exp_rels.delete();
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (pat[i] && cnt < 6) begin
                exp_rels.push_back(i + 1);
                cnt++;
            end
        end
        b = AW'($urandom);
        launch(1'b0, b, 6);
        ticks(34);
        check_job(1'b0, b, 6, 1'b0);
        for (int k = 0; k < 6 && k < wr_log.size(); k++) chk("rand_wr_cycle", wr_log[k].rel, exp_rels[k]);
        vpat.delete();

        // Zero-length job
        job_vecs.delete();
        b = AW'($urandom);
        launch(1'b0, b, 0);
        ticks(4);
        check_job(1'b0, b, 0, 1'b1);

        // Reset mid-job after two of five writes
        job_vecs.delete();
        for (int k = 0; k < 5; k++) job_vecs.push_back(rand_vec());
        mem[11'h302] = fill(16'h5A5A);
        launch(1'b0, 11'h300, 5);
        ticks(2);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_cen", sram_cen, 1);
        chk("mid_rst_wen", sram_wen, 1);
        chk("mid_rst_addr", sram_addr, 0);
        chk("mid_rst_d", sram_d, 0);
        chk("mid_rst_rd", ofifo_rd, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        ticks(3);
        reset = 1'b1;
        fifo_q.delete();
        ticks(3);
        $display("job reset-abort writes=%0d dones=%0d", wr_log.size(), done_rels.size());
        chk("abort_writes", wr_log.size(), 2);
        chk("abort_no_done", done_rels.size(), 0);
        chk("abort_mem0", mem[11'h300], job_vecs[0]);
        chk("abort_mem1", mem[11'h301], job_vecs[1]);
        chk("abort_mem2", mem[11'h302], fill(16'h5A5A));
        chk("abort_idle", busy, 0);

        // Start while busy and start during done are both ignored
        job_vecs.delete();
        for (int k = 0; k < 4; k++) job_vecs.push_back(rand_vec());
        b = 11'h0C0;
        launch(1'b0, b, 4);
        tick();
        start = 1'b1; acc_en = 1'b1; base_addr = 11'h140; num_vec = 11'd2;
        tick();
        start = 1'b0;
        ticks(2);
        fifo_q.push_back(rand_vec());
        fifo_q.push_back(rand_vec());
        start = 1'b1; acc_en = 1'b0; base_addr = 11'h180; num_vec = 11'd2;
        tick();
        start = 1'b0;
        ticks(5);
        check_job(1'b0, b, 4, 1'b1);
        fifo_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psum_drain.md
Name: psum_drain

Overview:
- Reader end of the corelet OFIFO. Pops output vectors (col x psum_bw) whenever the OFIFO reports valid, and writes them to the PSUM SRAM at consecutive addresses starting at a programmed base.
- In accumulate mode, each write is a read-modify-write: the stored partial sum is read and added elementwise before write-back.
- Sits between the corelet OFIFO port and the PSUM SRAM macro, under the top-level controller.

Parameters:
- col, 8, number of psum lanes per vector
- psum_bw, 16, bit-width of each psum lane
- addr_w, 11, PSUM SRAM address width

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  one-cycle pulse that launches a drain job; sampled only in IDLE
- acc_en  input  1  captured at start; 1 = read-modify-write accumulate, 0 = plain write
- base_addr  input  addr_w  first SRAM address; captured at start
- num_vec  input  addr_w  number of vectors to drain; captured at start
- ofifo_valid  input  1  OFIFO holds at least one full vector
- ofifo_out  input  col*psum_bw  OFIFO head vector, show-ahead (valid while ofifo_valid=1)
- ofifo_rd  output  1  pops the OFIFO head at the clock edge
- sram_cen  output  1  SRAM chip enable, active-low
- sram_wen  output  1  SRAM write enable, active-low (1 = read)
- sram_addr  output  addr_w  SRAM address
- sram_d  output  col*psum_bw  SRAM write data
- sram_q  input  col*psum_bw  SRAM read data, valid one cycle after a read access
- busy  output  1  high from the cycle after start until done
- done  output  1  one-cycle pulse when the job completes

Behaviour:
- Reset values (asynchronous, while reset=0):
  - state=IDLE, ofifo_rd=0, sram_cen=1, sram_wen=1, sram_addr=0, sram_d=0, busy=0, done=0.
  - All counters are zeroed.
  - Reset asserted mid-job aborts immediately. No done pulse. Already-popped data is lost.
- States: IDLE, WR, RD, ACC, FIN.
- IDLE:
  - start=1 latches acc_en, base_addr into addr, and num_vec into remaining.
  - remaining=0 goes to FIN. Otherwise acc_en ? RD : WR.
- WR (plain write; sram_* and ofifo_rd are combinational from state, ofifo_valid and addr):
  - Each cycle with ofifo_valid=1: ofifo_rd=1, sram_cen=0, sram_wen=0, sram_addr=addr, sram_d=ofifo_out.
  - Then addr+1 and remaining-1. When remaining reaches 0, go to FIN.
  - Throughput is 1 vector/cycle. ofifo_valid=0 means a stall with no SRAM access.
- RD:
  - When ofifo_valid=1: sram_cen=0, sram_wen=1, sram_addr=addr. Go to ACC.
  - The OFIFO is not popped in RD.
  - ofifo_valid=0 stalls in RD with no SRAM access.
- ACC:
  - ofifo_rd=1, sram_cen=0, sram_wen=0, sram_addr=addr.
  - sram_d lane i = sram_q lane i + ofifo_out lane i, two's-complement, truncated to psum_bw (wraps, no saturation).
  - Then addr+1 and remaining-1. Go to FIN when remaining reaches 0, otherwise back to RD.
  - Throughput is 1 vector per 2 cycles.
  - ACC always pops. ofifo_valid was checked in RD, and the OFIFO has no other reader during a job.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- busy = (state != IDLE) && (state != FIN).
- Address wraps modulo 2^addr_w with no error.
- Lanes pack as [i*psum_bw +: psum_bw], lane 0 at the LSBs, matching the OFIFO packing.
- Job boundaries:
  - start while not in IDLE is ignored.
  - start in the same cycle as done (FIN) is ignored. The controller re-issues it after done.
- Latency:
  - First SRAM write occurs 1 cycle after start (plain mode) or 2 cycles after start (accumulate), given ofifo_valid=1.
  - done rises 1 cycle after the last write.

Decomposition:
- Shared package (psum_pkg): state encoding enum, lane-slice helper constants, and an SRAM access type (cen, wen, addr, d bundle).
- One natural sub-module, psum_lane_add: a parameterised col-lane wrap-around adder, combinational. It is reused later by SFU-side accumulation.
- The FSM, counters and handshake stay in psum_drain.

Test Plan:
- Plain write:
  - Stimulus: acc_en=0, base=0x010, num_vec=4, ofifo_valid held 1, vectors lane0=1..4.
  - Required response: 4 consecutive writes to 0x010..0x013 in cycles 1-4, ofifo_rd high 4 cycles, done in cycle 5.
- Stall:
  - Stimulus: acc_en=0, num_vec=3, ofifo_valid toggling 1,0,0,1,1.
  - Required response: writes only in valid cycles, addresses contiguous, no access when valid=0, done after the third write.
- Accumulate:
  - Stimulus: acc_en=1, base=0x020, num_vec=2. SRAM preloaded with lane values 100 and -5. OFIFO lanes 23 and 7.
  - Required response: alternating read/write at 0x020 then 0x021. Stored values 123 and 2. Two pops total.
- Overflow and address wrap:
  - Stimulus: acc_en=1, stored 0x7FFF + ofifo 0x0001 in lane 3, base=0x7FF, num_vec=2.
  - Required response: lane 3 writes 0x8000. Second vector goes to address 0x000.
- Zero length and reset:
  - Stimulus 1: num_vec=0.
  - Required response 1: no SRAM access, no pop, done 1 cycle after start.
  - Stimulus 2: reset pulled low mid-job after 2 of 5 writes.
  - Required response 2: outputs return to reset values asynchronously, with no done pulse.
- Start while busy:
  - Stimulus: second start pulse during a 4-vector job.
  - Required response: ignored. Exactly 4 writes, one done pulse.
